// File: rtl/local_mem_resp_pkg.sv
// Shared types and constants for the local-memory Avalon-MM responder.
package local_mem_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WR_BURST = 2'd1,
    ST_RD_BURST = 2'd2
  } resp_state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Galois form, taps 16,14,13,11 (maximal length)
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/local_mem_avmm_responder_if.sv
// Avalon-MM burst bus between an AFU master and the local-memory responder.
interface local_mem_avmm_responder_if #(
  parameter int DATA_WIDTH       = 512,
  parameter int ADDR_WIDTH       = 27,
  parameter int BURSTCOUNT_WIDTH = 7
) ();

  logic                        waitrequest;
  logic                        read;
  logic                        write;
  logic [ADDR_WIDTH-1:0]       address;
  logic [BURSTCOUNT_WIDTH-1:0] burstcount;
  logic [DATA_WIDTH-1:0]       writedata;
  logic [DATA_WIDTH/8-1:0]     byteenable;
  logic [DATA_WIDTH-1:0]       readdata;
  logic                        readdatavalid;

  modport master (
    input  waitrequest, readdata, readdatavalid,
    output read, write, address, burstcount, writedata, byteenable
  );

  modport slave (
    output waitrequest, readdata, readdatavalid,
    input  read, write, address, burstcount, writedata, byteenable
  );

endinterface

// File: rtl/local_mem_resp_ram.sv
// Byte-lane simple dual-port RAM: one-cycle registered read; a same-cycle write
// to the read address is forwarded per enabled byte (write-before-read).
module local_mem_resp_ram #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_BITS  = 10
) (
  input  logic                    i_clk,
  input  logic                    i_we,
  input  logic [ADDR_BITS-1:0]    i_waddr,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_be,
  input  logic                    i_re,
  input  logic [ADDR_BITS-1:0]    i_raddr,
  output logic [DATA_WIDTH-1:0]   o_rdata
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_BITS;

  logic w_addr_hit;
  assign w_addr_hit = i_we && (i_waddr == i_raddr);

  for (genvar b = 0; b < NB; b++) begin : g_lane
    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_q;

    always_ff @(posedge i_clk) begin
      if (i_we && i_be[b]) begin
        r_mem[i_waddr] <= i_wdata[b*8 +: 8];
      end
      if (i_re) begin
        r_q <= (w_addr_hit && i_be[b]) ? i_wdata[b*8 +: 8] : r_mem[i_raddr];
      end
    end

    assign o_rdata[b*8 +: 8] = r_q;
  end

endmodule

// File: rtl/local_mem_avmm_responder.sv
// Avalon-MM burst responder for a local-memory bank; read beat 0 is valid after edge N+2, waitrequest held high in RD_BURST.
// Define LOCAL_MEM_RESPONDER_BP_EN to add LFSR-driven random waitrequest in IDLE/WR_BURST.
module local_mem_avmm_responder #(
  parameter int DATA_WIDTH       = 512,
  parameter int ADDR_WIDTH       = 27,
  parameter int BURSTCOUNT_WIDTH = 7,
  parameter int MEM_DEPTH_LOG2   = 10
) (
  input  logic                      clk,
  input  logic                      reset_n,
  local_mem_avmm_responder_if.slave avmm
);

  import local_mem_resp_pkg::*;

  localparam int AW = MEM_DEPTH_LOG2;
  localparam int BW = BURSTCOUNT_WIDTH;

  resp_state_e           r_state, w_state_nxt;
  logic [AW-1:0]         r_base, w_base_nxt;
  logic [BW-1:0]         r_idx, w_idx_nxt;
  logic [BW-1:0]         r_total, w_total_nxt;
  logic [BW-1:0]         w_burst_len;
  logic [AW-1:0]         w_cmd_addr, w_beat_addr, w_waddr;
  logic                  w_we, w_re, w_last, w_bp, w_waitreq;
  logic                  r_rd_pipe, r_rdv;
  logic [DATA_WIDTH-1:0] w_ram_q, r_rdata;
  logic                  w_unused_addr;

  assign w_cmd_addr    = avmm.address[AW-1:0];
  assign w_unused_addr = ^avmm.address[ADDR_WIDTH-1:AW];
  assign w_burst_len   = (avmm.burstcount == '0) ? BW'(1) : avmm.burstcount;
  assign w_beat_addr   = r_base + AW'(r_idx);
  assign w_last        = (r_idx == r_total - BW'(1));

`ifdef LOCAL_MEM_RESPONDER_BP_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  assign w_bp = r_lfsr[0];
`else
  assign w_bp = 1'b0;
`endif

  assign w_waitreq = !reset_n || (r_state == ST_RD_BURST) || w_bp;

  always_comb begin
    w_state_nxt = r_state;
    w_base_nxt  = r_base;
    w_idx_nxt   = r_idx;
    w_total_nxt = r_total;
    w_we        = 1'b0;
    w_re        = 1'b0;
    w_waddr     = w_beat_addr;
    case (r_state)
      ST_IDLE: begin
        // write wins when both strobes are presented together
        if (!w_waitreq && avmm.write) begin
          w_we        = 1'b1;
          w_waddr     = w_cmd_addr;
          w_base_nxt  = w_cmd_addr;
          w_total_nxt = w_burst_len;
          if (w_burst_len != BW'(1)) begin
            w_idx_nxt   = BW'(1);
            w_state_nxt = ST_WR_BURST;
          end else begin
            w_idx_nxt = '0;
          end
        end else if (!w_waitreq && avmm.read) begin
          w_base_nxt  = w_cmd_addr;
          w_total_nxt = w_burst_len;
          w_idx_nxt   = '0;
          w_state_nxt = ST_RD_BURST;
        end
      end
      ST_WR_BURST: begin
        if (!w_waitreq && avmm.write) begin
          w_we = 1'b1;
          if (w_last) begin
            w_idx_nxt   = '0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_idx_nxt = r_idx + BW'(1);
          end
        end
      end
      ST_RD_BURST: begin
        w_re = 1'b1;
        if (w_last) begin
          w_idx_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_idx_nxt = r_idx + BW'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_base    <= '0;
      r_idx     <= '0;
      r_total   <= '0;
      r_rd_pipe <= 1'b0;
      r_rdv     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_base    <= w_base_nxt;
      r_idx     <= w_idx_nxt;
      r_total   <= w_total_nxt;
      r_rd_pipe <= w_re;
      r_rdv     <= r_rd_pipe;
    end
  end

  // output stage gives the second cycle of read latency
  always_ff @(posedge clk) begin
    if (r_rd_pipe) begin
      r_rdata <= w_ram_q;
    end
  end

  local_mem_resp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_BITS  (AW)
  ) u_ram (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (avmm.writedata),
    .i_be    (avmm.byteenable),
    .i_re    (w_re),
    .i_raddr (w_beat_addr),
    .o_rdata (w_ram_q)
  );

  assign avmm.waitrequest   = w_waitreq;
  assign avmm.readdatavalid = r_rdv;
  assign avmm.readdata      = r_rdata;

endmodule
